// File: rtl/seq_pkg.sv
// Shared encodings for the serial "1011" link: generator FSM states,
// default pattern, and detector state codes.
package seq_pkg;

  localparam int unsigned PAT_W = 4;
  localparam logic [PAT_W-1:0] DEF_PATTERN = 4'b1011;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_GAP   = 3'd2,
    S_DONE  = 3'd3
  } gen_state_e;

  // Detector side of the link; kept here so both ends decode one source.
  typedef enum logic [2:0] {
    DET_IDLE  = 3'd0,
    DET_S1    = 3'd1,
    DET_S10   = 3'd2,
    DET_S101  = 3'd3,
    DET_S1011 = 3'd4
  } det_state_e;

endpackage

// File: rtl/sequence_generator_piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first, async active-low clear.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load wins over shift so a reload on the last bit restarts the pattern.
  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift_en) begin
      data_d = {data_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/sequence_generator.sv
// Bit-serial pattern transmitter: sends PATTERN MSB-first `count` times,
// with optional idle gap cycles between repetitions and a stall freeze.
module sequence_generator
  import seq_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(DEF_PATTERN),
  parameter int unsigned      CNT_W   = 8,
  parameter int unsigned      GAP     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             stall,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state
);

  localparam int unsigned BIT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  gen_state_e       state_q, state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             sh_load;
  logic             sh_shift;
  logic             sh_msb;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk     (clk),
    .rst_n   (rst),
    .load    (sh_load),
    .shift_en(sh_shift),
    .din     (PATTERN),
    .msb     (sh_msb)
  );

  // Next-state and counter update; stall freezes everything in SHIFT/GAP.
  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            sh_load   = 1'b1;
            rep_cnt_d = count;
            bit_cnt_d = '0;
            state_d   = S_SHIFT;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (!stall) begin
          if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
            rep_cnt_d = rep_cnt_q - CNT_W'(1);
            bit_cnt_d = '0;
            if (rep_cnt_q == CNT_W'(1)) begin
              sh_shift = 1'b1;
              state_d  = S_DONE;
            end else if (GAP > 0) begin
              sh_shift  = 1'b1;
              gap_cnt_d = '0;
              state_d   = S_GAP;
            end else begin
              sh_load = 1'b1;
            end
          end else begin
            sh_shift  = 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!stall) begin
          if (gap_cnt_q == GAP_W'(GAP - 1)) begin
            sh_load   = 1'b1;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = S_SHIFT;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rep_cnt_q <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rep_cnt_q <= rep_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Outputs decode straight from state flops so reset clears them at once.
  assign out       = (state_q == S_SHIFT) ? sh_msb : 1'b0;
  assign out_valid = (state_q == S_SHIFT) && !stall;
  assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
  assign done      = (state_q == S_DONE);
  assign state     = 3'(state_q);

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench for sequence_generator: per-cycle scoreboard of expected
// outputs, plus job-level checks (done latency, valid bits, 1011 detections).
module tb_sequence_generator;

  typedef struct packed {
    logic       out;
    logic       valid;
    logic       busy;
    logic       done;
    logic [2:0] st;
  } obs_t;

  typedef struct {
    int sel;          // 0: GAP=0 instance, 1: GAP=2 instance
    int count;
    int stall_from;   // cycle index after start edge; 0 = no stall
    int stall_len;
    int restart_at;   // cycle at which a second start(count=5) is pulsed
    int exp_cycles;   // cycles from start edge to done pulse
    int exp_valid;
    int exp_spacing;  // detection spacing to check; 0 = skip
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0, stall0 = 1'b0;
  logic       start1 = 1'b0, stall1 = 1'b0;
  logic [7:0] count0 = '0, count1 = '0;
  logic       out0, val0, busy0, done0;
  logic       out1, val1, busy1, done1;
  logic [2:0] state0, state1;

  int tests = 0;
  int fails = 0;
  logic [3:0] pat = 4'b1011;

  always #5 clk = ~clk;

  sequence_generator #(.GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .count(count0), .stall(stall0),
    .out(out0), .out_valid(val0), .busy(busy0), .done(done0), .state(state0)
  );

  sequence_generator #(.GAP(2)) dut2 (
    .clk(clk), .rst(rst), .start(start1), .count(count1), .stall(stall1),
    .out(out1), .out_valid(val1), .busy(busy1), .done(done1), .state(state1)
  );

  function automatic obs_t get_obs(input int sel);
    obs_t o;
    if (sel == 0) o = '{out0, val0, busy0, done0, state0};
    else          o = '{out1, val1, busy1, done1, state1};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [7:0] cnt, input logic stl);
    if (sel == 0) begin start0 = st; count0 = cnt; stall0 = stl; end
    else          begin start1 = st; count1 = cnt; stall1 = stl; end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    obs_t q[$];
    obs_t e, a, base;
    int   n, done_cyc, vcnt, det, det_first, det_last;
    logic [3:0] win;
    logic [7:0] cur_cnt;
    logic st, stl;
    // expected stream: bits, optional gap cycles, done pulse, one idle cycle
    for (int r = 0; r < v.count; r++) begin
      for (int b = 0; b < 4; b++) q.push_back('{pat[3-b], 1'b1, 1'b1, 1'b0, 3'd1});
      if (v.sel == 1 && r < v.count - 1)
        for (int g = 0; g < 2; g++) q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 3'd2});
    end
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 3'd3});
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 3'd0});
    if (v.stall_len > 0) begin
      base = q[v.stall_from-1];
      base.valid = 1'b0;
      for (int k = 0; k < v.stall_len; k++) q.insert(v.stall_from - 1, base);
    end

    n = 0; done_cyc = -1; vcnt = 0; det = 0; det_first = -1; det_last = -1; win = '0;
    cur_cnt = 8'(v.count);
    @(negedge clk);
    drive(v.sel, 1'b1, cur_cnt, 1'b0);
    while (q.size() > 0) begin
      @(negedge clk);
      n++;
      st  = (n == v.restart_at);
      stl = (v.stall_len > 0) && (n >= v.stall_from) && (n < v.stall_from + v.stall_len);
      if (st) cur_cnt = 8'd5;
      drive(v.sel, st, cur_cnt, stl);
      #1;
      a = get_obs(v.sel);
      e = q.pop_front();
      check($sformatf("v%0d cyc%0d obs", idx, n), 32'(a), 32'(e));
      if (a.done && done_cyc < 0) done_cyc = n;
      if (a.valid) begin
        vcnt++;
        win = {win[2:0], a.out};
        if (win == 4'b1011) begin
          det++;
          if (det_first < 0) det_first = n;
          det_last = n;
        end
      end
    end
    drive(v.sel, 1'b0, cur_cnt, 1'b0);
    check($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_cycles));
    check($sformatf("v%0d valid_bits", idx), 32'(vcnt), 32'(v.exp_valid));
    check($sformatf("v%0d detections", idx), 32'(det), 32'(v.count));
    if (v.exp_spacing > 0)
      check($sformatf("v%0d det_spacing", idx), 32'(det_last - det_first), 32'(v.exp_spacing));
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 1,   0, 0, 0, 5,    4,    0};
    vecs[1]  = '{0, 2,   0, 0, 0, 9,    8,    4};
    vecs[2]  = '{1, 2,   0, 0, 0, 11,   8,    0};
    vecs[3]  = '{0, 3,   7, 3, 0, 16,   12,   0};
    vecs[4]  = '{0, 0,   0, 0, 0, 1,    0,    0};
    vecs[5]  = '{0, 2,   0, 0, 2, 9,    8,    4};
    vecs[6]  = '{0, 1,   0, 0, 5, 5,    4,    0};
    vecs[7]  = '{1, 3,   0, 0, 0, 17,   12,   0};
    vecs[8]  = '{1, 1,   0, 0, 0, 5,    4,    0};
    vecs[9]  = '{1, 2,   5, 2, 0, 13,   8,    0};
    vecs[10] = '{0, 255, 0, 0, 0, 1021, 1020, 0};
    vecs[11] = '{1, 2,   0, 0, 3, 11,   8,    0};

    // reset state
    #1;
    check("rst dut0 obs", 32'(get_obs(0)), 32'h0);
    check("rst dut2 obs", 32'(get_obs(1)), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // asynchronous reset in the middle of SHIFT
    @(negedge clk);
    drive(0, 1'b1, 8'd3, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 8'd3, 1'b0);
    repeat (4) @(negedge clk);
    #1;
    check("pre_rst busy", 32'(busy0), 32'h1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst obs", 32'(get_obs(0)), 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("in_rst cyc%0d obs", k), 32'(get_obs(0)), 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;
    begin
      vec_t fresh;
      fresh = '{0, 2, 0, 0, 0, 9, 8, 4};
      run_vec(99, fresh);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sequence_generator.md
Name: sequence_generator

Overview:
Bit-serial pattern transmitter, the generating end of the serial "1011" detection link. On a start request it emits a fixed WIDTH-bit pattern MSB-first, repeated a requested number of times, with optional idle gap bits between repetitions. A stall input freezes emission. Output feeds the sequence detector's `in`, and DUT-level benches use it as the stimulus source.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
PATTERN, 4'b1011, pattern emitted MSB first
CNT_W, 8, width of repetition count
GAP, 0, number of idle cycles (out=0, out_valid=0) between repetitions; 0 = back-to-back

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  request pulse; sampled only in IDLE
count  input  CNT_W  repetitions to send; captured with start
stall  input  1  freeze emission while 1 (SHIFT/GAP only)
out  output  1  serial data bit
out_valid  output  1  out carries a pattern bit this cycle
busy  output  1  1 in SHIFT or GAP
done  output  1  one-cycle completion pulse
state  output  3  current FSM state (debug)

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, bit_cnt=0, rep_cnt=0, gap_cnt=0; out=0, out_valid=0, busy=0, done=0. A reset mid-transmission aborts immediately; no done pulse.
- State encoding: IDLE=3'd0, SHIFT=3'd1, GAP=3'd2, DONE=3'd3; other codes -> IDLE on next edge.
- Outputs are Moore/registered-derived: out = shreg[WIDTH-1] in SHIFT, else 0; out_valid = (state==SHIFT) && !stall; busy = SHIFT||GAP; done = (state==DONE).
- IDLE: start=1 and count!=0 at edge E0 -> shreg<=PATTERN, rep_cnt<=count, bit_cnt<=0, state<=SHIFT. First bit is visible in the cycle after E0 (latency 1). start=1 with count==0 -> state<=DONE (done pulse, no bits).
- SHIFT, stall=0: each edge shifts shreg left by 1, bit_cnt++. At the edge that consumes bit WIDTH-1: rep_cnt--. If the new rep_cnt==0 -> DONE. Else if GAP>0 -> GAP with gap_cnt<=0. Else shreg<=PATTERN, bit_cnt<=0, and SHIFT continues with no idle cycle.
- GAP, stall=0: gap_cnt++ each edge; after GAP cycles shreg<=PATTERN, bit_cnt<=0, state<=SHIFT.
- stall=1 in SHIFT/GAP: all registers hold; out keeps its value but out_valid=0. stall is ignored in IDLE/DONE.
- DONE: lasts exactly one cycle, then IDLE. start in the DONE cycle is ignored.
- start while busy is ignored; count is not re-sampled.
- Total valid bits per job = WIDTH*count. With stall=0, cycle count from E0 to the done pulse = WIDTH*count + GAP*(count-1) + 1.
- Counter widths: rep_cnt CNT_W bits; bit_cnt and gap_cnt sized by $clog2. count=2^CNT_W-1 must not overflow.

Decomposition:
- Shared package seq_pkg: state encodings (IDLE/SHIFT/GAP/DONE), default pattern constant 4'b1011, and the detector's state codes, so generator and detector benches share one source.
- One natural sub-module, piso_shift_reg: parallel load, shift enable, MSB out, async active-low clear. The FSM and counters stay in sequence_generator.

Test Plan:
- Reset then start=1, count=1, GAP=0 -> out_valid high 4 cycles, out=1,0,1,1; done pulses in cycle 5; busy low afterwards.
- count=2, GAP=0, out wired to the detector -> stream 10111011; detector out asserts twice, 4 cycles apart.
- count=2, GAP=2 -> 1011, two cycles with out_valid=0 and out=0, 1011, then done; 11 cycles total.
- count=3 with stall=1 for 3 cycles during bit 2 of rep 2 -> out holds, out_valid=0 for 3 cycles; sequence then resumes intact; done delayed by exactly 3 cycles.
- start with count=0 -> no valid bits; done pulses the next cycle. A second start while busy (count=5) is ignored: only the original count's bits are sent.
- rst driven low mid-SHIFT (asynchronously, between edges) -> out, out_valid, busy and state go to 0 immediately; no done pulse; a fresh start after release emits from bit 0.
